// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, the jump opcode and the
// {instr, pc} pair held in the output buffer.
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OPC_J = 6'h02;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pair_t;

endpackage

// File: rtl/ifetch_fifo2.sv
// Two-entry synchronous FIFO of fetched {instr, pc} pairs with flush; head is
// always presented combinationally and reads as zero straight out of reset.
module ifetch_fifo2
  import ifetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  fetch_pair_t data_i,
  output fetch_pair_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  fetch_pair_t mem_q [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: pc register, IDLE/FETCH/HOLD sequencer and a 2-entry
// output buffer. Optional jump predecode enabled by IFETCH_JUMP_PREDECODE_EN.
module instruction_fetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  pc_fetch_next;
  logic         fifo_full, fifo_empty;
  logic         push, pop;
  fetch_pair_t  fifo_in, fifo_head;

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = {2'b00, pc_q[31:2]};
  assign out_valid = !fifo_empty;

  // A redirect flushes the buffer, so neither the current fetch nor a pop is applied.
  assign push = imem_req && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  assign pc_plus4 = pc_q + 32'd4;
`ifdef IFETCH_JUMP_PREDECODE_EN
  assign pc_fetch_next = (imem_instr[31:26] == OPC_J)
                       ? {pc_plus4[31:28], imem_instr[25:0], 2'b00}
                       : pc_plus4;
`else
  assign pc_fetch_next = pc_plus4;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = ST_FETCH;
      pc_d    = {redirect_pc[31:2], 2'b00};
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FETCH;
        ST_FETCH: begin
          pc_d = pc_fetch_next;
          // Buffer already holds one entry and nothing leaves: this push fills it.
          if (!fifo_empty && !pop) state_d = ST_HOLD;
        end
        ST_HOLD: if (pop || !fifo_full) state_d = ST_FETCH;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign fifo_in = '{instr: imem_instr, pc: pc_q};

  ifetch_fifo2 u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (fifo_in),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_instr = fifo_head.instr;
  assign out_pc    = fifo_head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure, redirect,
// optional jump predecode and mid-stream reset.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int nchk  = 0;
  int npass = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // Words 0..3 are the program; elsewhere a non-jump word tagged with its byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] widx);
    case (widx)
      32'd0:   mem_word = 32'h2231_0000;
      32'd1:   mem_word = 32'h2008_004b;
      32'd2:   mem_word = 32'h014a_6020;
      32'd3:   mem_word = 32'h0810_0007;
      default: mem_word = 32'hC000_0000 | {widx[29:0], 2'b00};
    endcase
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] j_pc, j_instr;

  initial begin
`ifdef IFETCH_JUMP_PREDECODE_EN
    j_pc    = 32'h0040_001C;
    j_instr = 32'hC040_001C;
`else
    j_pc    = 32'h0000_0010;
    j_instr = 32'hC000_0010;
`endif
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(negedge clk);

    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req",   {31'd0, imem_req},  32'd0);
    chk("rst_pc",    out_pc,             32'd0);
    chk("rst_instr", out_instr,          32'd0);
    chk("rst_addr",  imem_addr,          32'd0);

    // Release: IDLE cycle, then FETCH, then stream 0,4,8,C and the next word.
    rst_n = 1'b1;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("f0_req",   {31'd0, imem_req},  32'd1);
    chk("f0_valid", {31'd0, out_valid}, 32'd0);
    chk("f0_addr",  imem_addr,          32'd0);
    tick();
    chk("s0_valid", {31'd0, out_valid}, 32'd1);
    chk("s0_pc",    out_pc,    32'h0);
    chk("s0_instr", out_instr, 32'h2231_0000);
    tick();
    chk("s1_pc",    out_pc,    32'h4);
    chk("s1_instr", out_instr, 32'h2008_004b);
    tick();
    chk("s2_pc",    out_pc,    32'h8);
    chk("s2_instr", out_instr, 32'h014a_6020);
    tick();
    chk("s3_pc",    out_pc,    32'hC);
    chk("s3_instr", out_instr, 32'h0810_0007);
    tick();
    chk("s4_valid", {31'd0, out_valid}, 32'd1);
    chk("s4_pc",    out_pc,    j_pc);
    chk("s4_instr", out_instr, j_instr);

    // Asynchronous reset pulse mid-stream.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_req",   {31'd0, imem_req},  32'd0);
    chk("arst_pc",    out_pc,             32'd0);
    chk("arst_instr", out_instr,          32'd0);
    chk("arst_addr",  imem_addr,          32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Backpressure from restart: two entries buffered, pc frozen at 8.
    tick();
    chk("bp_f0_addr", imem_addr, 32'd0);
    tick();
    chk("bp_f1_addr", imem_addr, 32'd1);
    chk("bp_f1_pc",   out_pc,    32'h0);
    tick();
    chk("bp_hold_req",  {31'd0, imem_req}, 32'd0);
    chk("bp_hold_addr", imem_addr,          32'd2);
    tick();
    tick();
    chk("bp_hold2_req",  {31'd0, imem_req},  32'd0);
    chk("bp_hold2_addr", imem_addr,          32'd2);
    chk("bp_hold2_pc",   out_pc,             32'h0);
    chk("bp_hold2_vld",  {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("rel0_pc", out_pc, 32'h0);
    tick();
    chk("rel1_pc",    out_pc,    32'h4);
    chk("rel1_instr", out_instr, 32'h2008_004b);
    chk("rel1_req",   {31'd0, imem_req}, 32'd1);
    tick();
    chk("rel2_pc",    out_pc,    32'h8);
    chk("rel2_instr", out_instr, 32'h014a_6020);
    tick();
    chk("rel3_pc", out_pc, 32'hC);

    // Fill the buffer, then redirect to a misaligned target.
    out_ready = 1'b0;
    tick();
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_pc",  out_pc,            32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    chk("rd1_valid", {31'd0, out_valid}, 32'd0);
    chk("rd1_req",   {31'd0, imem_req},  32'd1);
    chk("rd1_addr",  imem_addr,          32'h10);
    out_ready = 1'b1;
    tick();
    chk("rd2_valid", {31'd0, out_valid}, 32'd1);
    chk("rd2_pc",    out_pc,    32'h40);
    chk("rd2_instr", out_instr, 32'hC000_0040);
    tick();
    chk("rd3_pc", out_pc, 32'h44);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
